// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a byte-addressed, big-endian data_memory.
// Optional macro ALIGN_CHECK_EN rejects (err + ack, no write) accesses whose address is not word aligned.
module data_mem_arbiter #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [ADDR_BUS_WIDTH-1:0] addr0,
  input  logic [ADDR_BUS_WIDTH-1:0] addr1,
  input  logic [DATA_BUS_WIDTH-1:0] wdata0,
  input  logic [DATA_BUS_WIDTH-1:0] wdata1,
  output logic                      ack0,
  output logic                      ack1,
  output logic [DATA_BUS_WIDTH-1:0] rdata0,
  output logic [DATA_BUS_WIDTH-1:0] rdata1,
  output logic                      err0,
  output logic                      err1,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
  output logic                      mem_write_en,
  input  logic [DATA_BUS_WIDTH-1:0] mem_read_data,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      r_owner;
  logic                      w_next_owner;
  logic                      r_last_owner;
  logic                      r_ack0;
  logic                      r_ack1;
  logic [DATA_BUS_WIDTH-1:0] r_rdata0;
  logic [DATA_BUS_WIDTH-1:0] r_rdata1;

  logic                      w_serve;
  logic                      w_sel_we;
  logic                      w_reject;
  logic                      w_other_req;
  logic [ADDR_BUS_WIDTH-1:0] w_sel_addr;
  logic [DATA_BUS_WIDTH-1:0] w_sel_wdata;
  logic [DATA_BUS_WIDTH-1:0] w_read_result;

  assign w_serve     = (r_state == S_SERVE);
  assign w_sel_addr  = r_owner ? addr1  : addr0;
  assign w_sel_wdata = r_owner ? wdata1 : wdata0;
  assign w_sel_we    = r_owner ? we1    : we0;
  assign w_other_req = r_owner ? req0   : req1;

`ifdef ALIGN_CHECK_EN
  assign w_reject = (w_sel_addr[1:0] != 2'b00);
`else
  assign w_reject = 1'b0;
`endif

  // Memory port is decoded from state so an async reset in SERVE kills the write strobe at once.
  assign mem_addr       = w_serve ? w_sel_addr  : '0;
  assign mem_write_data = w_serve ? w_sel_wdata : '0;
  assign mem_write_en   = w_serve & w_sel_we & ~w_reject;
  assign w_read_result  = (w_sel_we | w_reject) ? '0 : mem_read_data;

  assign busy   = (r_state != S_IDLE);
  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_next_owner = r_owner;
    unique case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          w_next_state = S_SERVE;
          w_next_owner = (req0 & req1) ? ~r_last_owner : req1;
        end
      end
      S_SERVE: w_next_state = S_ACK;
      S_ACK: begin
        // The port being acked is ignored here; only the other one can be granted back-to-back.
        if (w_other_req) begin
          w_next_state = S_SERVE;
          w_next_owner = ~r_owner;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      r_ack0  <= w_serve & ~r_owner;
      r_ack1  <= w_serve & r_owner;
      if (w_serve) begin
        r_last_owner <= r_owner;
        if (r_owner) r_rdata1 <= w_read_result;
        else         r_rdata0 <= w_read_result;
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  logic r_err0;
  logic r_err1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_err0 <= w_serve & ~r_owner & w_reject;
      r_err1 <= w_serve & r_owner & w_reject;
    end
  end

  assign err0 = r_err0;
  assign err1 = r_err1;
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a 64-byte big-endian memory, a transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req [2];
  logic          we [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1, err0, err1, mem_write_en, busy;
  logic [DW-1:0] rdata0, rdata1, mem_write_data, mem_read_data;
  logic [AW-1:0] mem_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  data_mem_arbiter #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Initial image: word 0 = 0000000A, word 4 = 33333333, word 12 = CCCCCCCC, other bytes = index.
  function automatic logic [7:0] init_byte(input int i);
    case (i / 4)
      0:       return (i == 3) ? 8'h0A : 8'h00;
      1:       return 8'h33;
      3:       return 8'hCC;
      default: return 8'(i);
    endcase
  endfunction

  // Memory the DUT drives: combinational big-endian read, write on negedge.
  logic [7:0] env_mem [64];
  assign mem_read_data = {env_mem[mem_addr[5:0]], env_mem[mem_addr[5:0] + 6'd1],
                          env_mem[mem_addr[5:0] + 6'd2], env_mem[mem_addr[5:0] + 6'd3]};
  initial begin
    for (int i = 0; i < 64; i++) env_mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (mem_write_en) begin
        env_mem[mem_addr[5:0]]         = mem_write_data[31:24];
        env_mem[mem_addr[5:0] + 6'd1]  = mem_write_data[23:16];
        env_mem[mem_addr[5:0] + 6'd2]  = mem_write_data[15:8];
        env_mem[mem_addr[5:0] + 6'd3]  = mem_write_data[7:0];
      end
    end
  end

  function automatic logic [31:0] env_word(input logic [5:0] a);
    return {env_mem[a], env_mem[a + 6'd1], env_mem[a + 6'd2], env_mem[a + 6'd3]};
  endfunction

  // Reference model: one access in flight; m_serve = port being served this cycle,
  // m_ack = port whose completion is reported this cycle (-1 = none).
  logic [7:0]  ref_mem [64];
  int          m_serve, m_ack, m_last;
  bit          m_ack_err;
  logic [31:0] m_rdata [2];

  function automatic logic [31:0] ref_word(input logic [5:0] a);
    return {ref_mem[a], ref_mem[a + 6'd1], ref_mem[a + 6'd2], ref_mem[a + 6'd3]};
  endfunction

  task automatic model_reset();
    m_serve = -1; m_ack = -1; m_last = 1; m_ack_err = 1'b0;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic compare_outputs();
    logic [31:0] e_addr, e_wd;
    bit          e_we;
    e_addr = '0; e_wd = '0; e_we = 1'b0;
    if (m_serve >= 0) begin
      e_addr = addr[m_serve];
      e_wd   = wdata[m_serve];
      e_we   = we[m_serve] && !(ALIGN_ON && addr[m_serve][1:0] != 2'b00);
    end
    check("busy", busy, (m_serve >= 0) || (m_ack >= 0));
    check("ack0", ack0, m_ack == 0);
    check("ack1", ack1, m_ack == 1);
    check("err0", err0, (m_ack == 0) && m_ack_err);
    check("err1", err1, (m_ack == 1) && m_ack_err);
    check("rdata0", rdata0, m_rdata[0]);
    check("rdata1", rdata1, m_rdata[1]);
    check("mem_addr", mem_addr, e_addr);
    check("mem_write_data", mem_write_data, e_wd);
    check("mem_write_en", mem_write_en, e_we);
  endtask

  task automatic model_step();
    int p;
    bit bad, c0, c1;
    if (m_serve >= 0) begin
      p   = m_serve;
      bad = ALIGN_ON && (addr[p][1:0] != 2'b00);
      if (bad) begin
        m_rdata[p] = '0;
      end else if (we[p]) begin
        for (int k = 0; k < 4; k++) ref_mem[addr[p][5:0] + 6'(k)] = wdata[p][31 - 8*k -: 8];
        m_rdata[p] = '0;
      end else begin
        m_rdata[p] = ref_word(addr[p][5:0]);
      end
      m_ack = p; m_ack_err = bad; m_last = p; m_serve = -1;
    end else begin
      c0 = req[0] && (m_ack != 0);
      c1 = req[1] && (m_ack != 1);
      m_ack = -1; m_ack_err = 1'b0;
      if (c0 && c1)  m_serve = 1 - m_last;
      else if (c0)   m_serve = 0;
      else if (c1)   m_serve = 1;
      else           m_serve = -1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        compare_outputs();
      end else begin
        compare_outputs();
        model_step();
      end
    end
  end

  // Called just after a posedge; returns one cycle after the ack with req dropped.
  task automatic do_access(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int ack_cyc);
    bit got;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    got = 1'b0; lat = 0; rd = '0; er = 1'b0; ack_cyc = -1;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if ((p == 0 && ack0 === 1'b1) || (p == 1 && ack1 === 1'b1)) begin
        got = 1'b1; lat = n; ack_cyc = cycle;
        rd = (p == 1) ? rdata1 : rdata0;
        er = (p == 1) ? err1 : err0;
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout port %0d: got no ack, required ack within 20 cycles", p);
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int          lat, ca0, ca1, cb0, cb1, acks_seen;
  logic [31:0] rd, rd_a0, rd_a1, rd_b0, rd_b1;
  logic        er;

  initial begin
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_ack0", ack0, 0);
    check("reset_rdata1", rdata1, 0);
    check("reset_mem_write_en", mem_write_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single read, latency T -> T+2
    do_access(0, 1'b0, 32'd4, 32'h0, lat, rd, er, ca0);
    check("t1_latency", lat, 3);
    check("t1_rdata0", rd, 32'h33333333);
    check("t1_err0", er, 0);

    // 2: port 1 write then read back
    do_access(1, 1'b1, 32'd8, 32'hDEADBEEF, lat, rd, er, ca0);
    check("t2_write_rdata1", rd, 32'h0);
    do_access(1, 1'b0, 32'd8, 32'h0, lat, rd, er, ca0);
    check("t2_read_rdata1", rd, 32'hDEADBEEF);
    check("t2_mem_word8", env_word(6'd8), 32'hDEADBEEF);

    // 3: simultaneous requests after reset, both held for two accesses each
    reset_dut();
    fork
      begin
        do_access(0, 1'b0, 32'd0, 32'h0, lat, rd_a0, er, ca0);
        do_access(0, 1'b0, 32'd0, 32'h0, lat, rd_b0, er, cb0);
      end
      begin
        do_access(1, 1'b0, 32'd4, 32'h0, lat, rd_a1, er, ca1);
        do_access(1, 1'b0, 32'd4, 32'h0, lat, rd_b1, er, cb1);
      end
    join
    check("t3_rdata0", rd_a0, 32'h0000000A);
    check("t3_rdata1", rd_a1, 32'h33333333);
    check("t3_ack1_gap", ca1 - ca0, 2);
    check("t3_ack0_second_gap", cb0 - ca0, 4);
    check("t3_ack1_second_gap", cb1 - ca0, 6);

    // 4: reset in the SERVE cycle of a write to word 12
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd12; wdata[0] = 32'h5A5A5A5A;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t4_mem_write_en", mem_write_en, 0);
    check("t4_busy", busy, 0);
    check("t4_rdata0", rdata0, 0);
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0; we[0] = 1'b0;
    acks_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 !== 1'b0 || ack1 !== 1'b0) acks_seen++;
    end
    check("t4_no_ack", acks_seen, 0);
    check("t4_mem_word12", env_word(6'd12), 32'hCCCCCCCC);
    @(posedge clk); #1;
    do_access(1, 1'b0, 32'd12, 32'h0, lat, rd, er, ca0);
    check("t4_req1_latency", lat, 3);
    check("t4_rdata1", rd, 32'hCCCCCCCC);

    // 5: misaligned write to byte 6
    do_access(0, 1'b1, 32'd6, 32'h11223344, lat, rd, er, ca0);
    check("t5_latency", lat, 3);
`ifdef ALIGN_CHECK_EN
    check("t5_err0", er, 1);
    check("t5_bytes6_7", {env_mem[6], env_mem[7]}, 16'h3333);
`else
    check("t5_err0", er, 0);
    check("t5_bytes6_7", {env_mem[6], env_mem[7]}, 16'h1122);
`endif

    // 6: ten idle cycles
    acks_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack0 !== 1'b0 || ack1 !== 1'b0) acks_seen++;
    end
    check("t6_no_ack", acks_seen, 0);
    check("t6_busy", busy, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_mem_write_en", mem_write_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
